// File: rtl/usr_pkg.sv
// Shared mode encoding and default width for the universal shift register.
package usr_pkg;

    typedef logic [1:0] usr_mode_t;

    localparam usr_mode_t MODE_HOLD = 2'b00;
    localparam usr_mode_t MODE_SHR  = 2'b01;
    localparam usr_mode_t MODE_SHL  = 2'b10;
    localparam usr_mode_t MODE_LOAD = 2'b11;

    localparam int DEFAULT_WIDTH = 4;

endpackage

// File: rtl/usr_bit_cell.sv
// One storage bit of the universal shift register.
// It selects between hold, left neighbour, right neighbour and the load bit.
module usr_bit_cell
    import usr_pkg::*;
(
    input  logic      clk,
    input  logic      reset,
    input  logic      en,
    input  usr_mode_t mode,
    input  logic      from_left,
    input  logic      from_right,
    input  logic      load_bit,
    output logic      q
);

    always_ff @(posedge clk) begin
        if (reset) begin
            q <= 1'b0;
        end else if (en) begin
            case (mode)
                MODE_SHR:  q <= from_left;
                MODE_SHL:  q <= from_right;
                MODE_LOAD: q <= load_bit;
                default:   q <= q;
            endcase
        end
    end

endmodule

// File: rtl/universal_shift_register.sv
// Parametrised hold / shift-right / shift-left / load register with a saturating shift counter.
// Optional macro USR_ROTATE_EN adds a rot input that feeds the discarded bit back in on shifts.
module universal_shift_register
    import usr_pkg::*;
#(
    parameter  int WIDTH = DEFAULT_WIDTH,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  usr_mode_t        mode,
    input  logic [WIDTH-1:0] d_in,
    input  logic             sin_r,
    input  logic             sin_l,
`ifdef USR_ROTATE_EN
    input  logic             rot,
`endif
    output logic [WIDTH-1:0] d_out,
    output logic             sout_r,
    output logic             sout_l,
    output logic [CNT_W-1:0] shift_cnt,
    output logic             full_shift
);

    logic             msb_fill;
    logic             lsb_fill;
    logic [WIDTH-1:0] shr_src;
    logic [WIDTH-1:0] shl_src;
    logic [CNT_W-1:0] cnt_next;

`ifdef USR_ROTATE_EN
    assign msb_fill = rot ? d_out[0]       : sin_r;
    assign lsb_fill = rot ? d_out[WIDTH-1] : sin_l;
`else
    assign msb_fill = sin_r;
    assign lsb_fill = sin_l;
`endif

    // Per-bit next value for each shift direction, ends included.
    assign shr_src = {msb_fill, d_out[WIDTH-1:1]};
    assign shl_src = {d_out[WIDTH-2:0], lsb_fill};

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        usr_bit_cell u_cell (
            .clk        (clk),
            .reset      (reset),
            .en         (en),
            .mode       (mode),
            .from_left  (shr_src[i]),
            .from_right (shl_src[i]),
            .load_bit   (d_in[i]),
            .q          (d_out[i])
        );
    end

    assign sout_r = d_out[0];
    assign sout_l = d_out[WIDTH-1];

    always_comb begin
        cnt_next = shift_cnt;
        case (mode)
            MODE_SHR, MODE_SHL: begin
                if (shift_cnt != CNT_W'(WIDTH)) begin
                    cnt_next = shift_cnt + 1'b1;
                end
            end
            MODE_LOAD: cnt_next = '0;
            default:   cnt_next = shift_cnt;
        endcase
    end

    // full_shift is registered alongside the counter so both change on the same edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            shift_cnt  <= '0;
            full_shift <= 1'b0;
        end else if (en) begin
            shift_cnt  <= cnt_next;
            full_shift <= (cnt_next == CNT_W'(WIDTH));
        end
    end

endmodule

// File: tb/tb_universal_shift_register.sv
// Self-checking bench for universal_shift_register: directed scenarios plus randomized
// traffic compared against an arithmetic reference model.
module tb_universal_shift_register;
    import usr_pkg::*;

    localparam int W  = 4;
    localparam int CW = $clog2(W + 1);

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          en = 1'b0;
    usr_mode_t     mode = MODE_HOLD;
    logic [W-1:0]  d_in = '0;
    logic          sin_r = 1'b0;
    logic          sin_l = 1'b0;
    logic          rot = 1'b0;
    logic [W-1:0]  d_out;
    logic          sout_r;
    logic          sout_l;
    logic [CW-1:0] shift_cnt;
    logic          full_shift;

    int checks = 0;
    int failures = 0;

    logic [W-1:0] mdl_q = '0;
    int           mdl_cnt = 0;

    universal_shift_register #(.WIDTH(W)) dut (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .mode       (mode),
        .d_in       (d_in),
        .sin_r      (sin_r),
        .sin_l      (sin_l),
`ifdef USR_ROTATE_EN
        .rot        (rot),
`endif
        .d_out      (d_out),
        .sout_r     (sout_r),
        .sout_l     (sout_l),
        .shift_cnt  (shift_cnt),
        .full_shift (full_shift)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Drive one cycle, advance the model by the same rules, then compare everything.
    task automatic step(input logic r, input logic e, input logic [1:0] m,
                        input logic [W-1:0] din, input logic sr, input logic sl, input logic ro);
        logic fill;
        logic rot_eff;
        reset = r; en = e; mode = m; d_in = din; sin_r = sr; sin_l = sl; rot = ro;
`ifdef USR_ROTATE_EN
        rot_eff = ro;
`else
        rot_eff = 1'b0;
`endif
        @(posedge clk);
        if (r) begin
            mdl_q = '0;
            mdl_cnt = 0;
        end else if (e) begin
            if (m == 2'd1) begin
                fill = rot_eff ? mdl_q[0] : sr;
                mdl_q = W'((int'(mdl_q) >> 1) + (int'(fill) << (W - 1)));
                mdl_cnt = (mdl_cnt < W) ? mdl_cnt + 1 : W;
            end else if (m == 2'd2) begin
                fill = rot_eff ? mdl_q[W-1] : sl;
                mdl_q = W'((int'(mdl_q) * 2 + int'(fill)) % (1 << W));
                mdl_cnt = (mdl_cnt < W) ? mdl_cnt + 1 : W;
            end else if (m == 2'd3) begin
                mdl_q = din;
                mdl_cnt = 0;
            end
        end
        #1;
        check_val("d_out", 64'(d_out), 64'(mdl_q));
        check_val("sout_r", 64'(sout_r), 64'(mdl_q[0]));
        check_val("sout_l", 64'(sout_l), 64'(mdl_q[W-1]));
        check_val("shift_cnt", 64'(shift_cnt), 64'(mdl_cnt));
        check_val("full_shift", 64'(full_shift), 64'(mdl_cnt == W));
    endtask

    initial begin
        logic [3:0] exp_sout;
        logic [3:0] sl_seq;

        // Reset and load
        step(1, 0, 0, '0, 0, 0, 0);
        step(1, 0, 0, '0, 0, 0, 0);
        check_val("rst_dout", 64'(d_out), 64'h0);
        check_val("rst_full", 64'(full_shift), 64'h0);
        step(0, 1, 3, 4'b1011, 0, 0, 0);
        check_val("load_1011", 64'(d_out), 64'hB);
        check_val("load_cnt", 64'(shift_cnt), 64'h0);

        // Serialise right: sout_r must read 1,1,0,1 before each shift
        exp_sout = 4'b1011;
        for (int i = 0; i < 4; i++) begin
            check_val("ser_sout_r", 64'(sout_r), 64'(exp_sout[i]));
            step(0, 1, 1, '0, 0, 0, 0);
        end
        check_val("ser_dout", 64'(d_out), 64'h0);
        check_val("ser_cnt", 64'(shift_cnt), 64'd4);
        check_val("ser_full", 64'(full_shift), 64'h1);
        step(0, 1, 1, '0, 0, 0, 0);
        check_val("sat_cnt", 64'(shift_cnt), 64'd4);

        // Deserialise left from reset: sin_l 1,0,0,1
        step(1, 0, 0, '0, 0, 0, 0);
        sl_seq = 4'b1001;
        for (int i = 3; i >= 0; i--) step(0, 1, 2, '0, 0, sl_seq[i], 0);
        check_val("deser_dout", 64'(d_out), 64'h9);
        check_val("deser_full", 64'(full_shift), 64'h1);
        step(0, 1, 3, 4'b0110, 0, 0, 0);
        check_val("reload_dout", 64'(d_out), 64'h6);
        check_val("reload_full", 64'(full_shift), 64'h0);

        // Enable gating
        step(0, 1, 3, 4'b1100, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 1, 4'b0011, 1, 1, 1);
        check_val("gate_dout", 64'(d_out), 64'hC);
        check_val("gate_cnt", 64'(shift_cnt), 64'h0);
        step(0, 1, 1, '0, 0, 0, 0);
        check_val("gate_release", 64'(d_out), 64'h6);

        // Reset priority mid-serialisation
        step(0, 1, 1, '0, 1, 0, 0);
        check_val("mid_cnt", 64'(shift_cnt), 64'd2);
        step(1, 1, 3, 4'b1111, 0, 0, 0);
        check_val("rstprio_dout", 64'(d_out), 64'h0);
        check_val("rstprio_cnt", 64'(shift_cnt), 64'h0);

`ifdef USR_ROTATE_EN
        // Rotate left: 1001 -> 0011, back to 1001 after W rotates
        step(0, 1, 3, 4'b1001, 0, 0, 0);
        step(0, 1, 2, '0, 0, 0, 1);
        check_val("rot_one", 64'(d_out), 64'h3);
        for (int i = 1; i < W; i++) step(0, 1, 2, '0, 0, 0, 1);
        check_val("rot_full", 64'(d_out), 64'h9);
        check_val("rot_cnt", 64'(shift_cnt), 64'(W));
`endif

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 99) < 3), ($urandom_range(0, 99) < 80),
                 2'($urandom_range(0, 3)), W'($urandom), 1'($urandom), 1'($urandom),
                 1'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
